// File: rtl/data_ram_slave.sv
// -----------------------------------------------------------------------------
// data_ram_slave
//
// Data-memory responder for the MEM stage. Holds a word-organised RAM of
// 2**ADDR_W 32-bit words and answers one load/store request at a time.
// Each accepted request is followed by WAIT_CYCLES wait states, then a
// one-cycle acknowledge. stallreq_o holds the pipeline until that ack.
//
// Parameters
//   ADDR_W       word-address bits (RAM depth = 2**ADDR_W words)
//   WAIT_CYCLES  wait states between accept and ack, 0..15
//
// Ports
//   clk          clock, rising edge
//   rst          asynchronous reset, active-low
//   mem_req_i    access request, held by MEM until mem_ack_o
//   mem_we_i     1 = store, 0 = load
//   mem_addr_i   byte address, bits [1:0] ignored
//   mem_sel_i    store byte enables, bit n -> data[8n+7:8n]
//   mem_data_i   store data
//   mem_data_o   load data, valid with mem_ack_o, held until next response
//   mem_ack_o    one-cycle completion pulse
//   mem_err_o    out-of-range address flag, valid with mem_ack_o
//   stallreq_o   stall request to ctrl (combinational)
// -----------------------------------------------------------------------------
module data_ram_slave #(
    parameter int unsigned ADDR_W      = 10,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_req_i,
    input  logic        mem_we_i,
    input  logic [31:0] mem_addr_i,
    input  logic [3:0]  mem_sel_i,
    input  logic [31:0] mem_data_i,
    output logic [31:0] mem_data_o,
    output logic        mem_ack_o,
    output logic        mem_err_o,
    output logic        stallreq_o
);

    localparam int unsigned DEPTH     = 32'd1 << ADDR_W;
    localparam bit          HAS_WAIT  = (WAIT_CYCLES > 32'd0);
    localparam logic [3:0]  WAIT_INIT = (WAIT_CYCLES > 32'd0) ? 4'(WAIT_CYCLES - 32'd1) : 4'd0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    // Any address bit above the RAM's byte-address span makes the access illegal.
    function automatic logic addr_out_of_range(input logic [31:0] addr);
        logic [31:0] upper;
        upper = addr >> (ADDR_W + 32'd2);
        return (upper != 32'd0);
    endfunction

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [3:0]  sel_q, sel_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rdata_q, rdata_d;
    logic        ack_q, ack_d;
    logic        err_q, err_d;

    logic [31:0] ram_q [DEPTH];

    logic              enter_resp_s;
    logic              acc_we_s;
    logic [31:0]       acc_addr_s;
    logic [3:0]        acc_sel_s;
    logic [31:0]       acc_wdata_s;
    logic [ADDR_W-1:0] acc_idx_s;
    logic              acc_oor_s;
    logic              ram_wr_s;

    // Next-state logic: accept in IDLE, count down in WAIT, single RESP cycle.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        we_d         = we_q;
        addr_d       = addr_q;
        sel_d        = sel_q;
        wdata_d      = wdata_q;
        enter_resp_s = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (mem_req_i) begin
                    we_d    = mem_we_i;
                    addr_d  = mem_addr_i;
                    sel_d   = mem_sel_i;
                    wdata_d = mem_data_i;
                    if (HAS_WAIT) begin
                        state_d = ST_WAIT;
                        cnt_d   = WAIT_INIT;
                    end else begin
                        // Zero wait states: the accept edge is also the RESP-entry edge.
                        state_d      = ST_RESP;
                        enter_resp_s = 1'b1;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d      = ST_RESP;
                    enter_resp_s = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = 4'd0;
            end
        endcase
    end

    // Select the access being completed: live inputs when completing straight
    // from IDLE (zero wait states), otherwise the request latched at accept.
    always_comb begin
        if (state_q == ST_IDLE) begin
            acc_we_s    = mem_we_i;
            acc_addr_s  = mem_addr_i;
            acc_sel_s   = mem_sel_i;
            acc_wdata_s = mem_data_i;
        end else begin
            acc_we_s    = we_q;
            acc_addr_s  = addr_q;
            acc_sel_s   = sel_q;
            acc_wdata_s = wdata_q;
        end
    end

    assign acc_idx_s = acc_addr_s[ADDR_W+1:2];
    assign acc_oor_s = addr_out_of_range(acc_addr_s);

    // rst gates the write so that reset asserted on the RESP-entry edge wins.
    assign ram_wr_s = enter_resp_s & acc_we_s & ~acc_oor_s & rst;

    // Response registers: loaded on the RESP-entry edge, ack/err cleared otherwise.
    always_comb begin
        ack_d = enter_resp_s;
        err_d = enter_resp_s & acc_oor_s;
        if (enter_resp_s) begin
            if (acc_oor_s || acc_we_s) begin
                rdata_d = 32'd0;
            end else begin
                rdata_d = ram_q[acc_idx_s];
            end
        end else begin
            rdata_d = rdata_q;
        end
    end

    // State, latched request and registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
            we_q    <= 1'b0;
            addr_q  <= 32'd0;
            sel_q   <= 4'd0;
            wdata_q <= 32'd0;
            rdata_q <= 32'd0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            sel_q   <= sel_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
        end
    end

    // RAM byte-lane writes; contents deliberately survive reset.
    always_ff @(posedge clk) begin
        if (ram_wr_s) begin
            for (int b = 0; b < 4; b++) begin
                if (acc_sel_s[b]) begin
                    ram_q[acc_idx_s][8*b +: 8] <= acc_wdata_s[8*b +: 8];
                end
            end
        end
    end

    assign mem_data_o = rdata_q;
    assign mem_ack_o  = ack_q;
    assign mem_err_o  = err_q;
    // Low in the ack cycle so the pipeline advances; forced low during reset.
    assign stallreq_o = mem_req_i & ~ack_q & rst;

endmodule

// File: tb/tb_data_ram_slave.sv
module tb_data_ram_slave;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    // Instance 0: WAIT_CYCLES=0, instance 1: WAIT_CYCLES=2
    logic        req0, we0, req1, we1;
    logic [31:0] addr0, wd0, addr1, wd1;
    logic [3:0]  sel0, sel1;
    logic [31:0] rd0, rd1;
    logic        ack0, err0, stall0, ack1, err1, stall1;

    int checks   = 0;
    int failures = 0;

    // Reference memory: word index = byte address / 4 for in-range addresses
    logic [31:0] ref_mem [2][1024];

    data_ram_slave #(.ADDR_W(10), .WAIT_CYCLES(0)) dut0 (
        .clk(clk), .rst(rst), .mem_req_i(req0), .mem_we_i(we0), .mem_addr_i(addr0),
        .mem_sel_i(sel0), .mem_data_i(wd0), .mem_data_o(rd0), .mem_ack_o(ack0),
        .mem_err_o(err0), .stallreq_o(stall0));

    data_ram_slave #(.ADDR_W(10), .WAIT_CYCLES(2)) dut1 (
        .clk(clk), .rst(rst), .mem_req_i(req1), .mem_we_i(we1), .mem_addr_i(addr1),
        .mem_sel_i(sel1), .mem_data_i(wd1), .mem_data_o(rd1), .mem_ack_o(ack1),
        .mem_err_o(err1), .stallreq_o(stall1));

    task automatic drive(input int d, input logic r, input logic w, input logic [31:0] a,
                         input logic [3:0] s, input logic [31:0] x);
        if (d == 0) begin
            req0 = r; we0 = w; addr0 = a; sel0 = s; wd0 = x;
        end else begin
            req1 = r; we1 = w; addr1 = a; sel1 = s; wd1 = x;
        end
    endtask

    // {ack, err, stall, data}
    function automatic logic [34:0] obs(input int d);
        if (d == 0) return {ack0, err0, stall0, rd0};
        else        return {ack1, err1, stall1, rd1};
    endfunction

    function automatic int exp_lat(input int d);
        return (d == 0) ? 1 : 3;
    endfunction

    function automatic void model_store(input int d, input logic [31:0] a, input logic [3:0] s,
                                        input logic [31:0] x);
        logic [31:0] w;
        if (a < 32'h0000_1000) begin
            w = ref_mem[d][a / 4];
            for (int b = 0; b < 4; b++)
                if (s[b]) w[8*b +: 8] = x[8*b +: 8];
            ref_mem[d][a / 4] = w;
        end
    endfunction

    function automatic logic [31:0] model_load(input int d, input logic [31:0] a);
        if (a < 32'h0000_1000) return ref_mem[d][a / 4];
        else                   return 32'd0;
    endfunction

    // One complete access with req held until ack; returns what was observed.
    task automatic acc(input int d, input logic w, input logic [31:0] a, input logic [3:0] s,
                       input logic [31:0] x, output logic [31:0] r, output logic e,
                       output int lat, output int stall_bad);
        logic [34:0] o;
        @(negedge clk);
        drive(d, 1'b1, w, a, s, x);
        #1;
        o = obs(d);
        stall_bad = (o[32] !== 1'b1) ? 1 : 0;
        @(posedge clk);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
            o = obs(d);
            if (o[34] !== 1'b1 && o[32] !== 1'b1) stall_bad++;
        end while (o[34] !== 1'b1 && lat < 40);
        if (o[32] !== 1'b0) stall_bad++;
        r = o[31:0];
        e = o[33];
        drive(d, 1'b0, 1'b0, 32'd0, 4'd0, 32'd0);
    endtask

    // Access plus full comparison of data, err, latency and stall behaviour.
    task automatic acc_check(input string nm, input int d, input logic w, input logic [31:0] a,
                             input logic [3:0] s, input logic [31:0] x);
        logic [31:0] r, er;
        logic e, ee;
        int lat, sb;
        ee = (a >= 32'h0000_1000);
        er = w ? 32'd0 : model_load(d, a);
        acc(d, w, a, s, x, r, e, lat, sb);
        if (w) model_store(d, a, s, x);
        checks++;
        if (r !== er) begin failures++; $display("FAIL %s data: got %h expected %h", nm, r, er); end
        checks++;
        if (e !== ee) begin failures++; $display("FAIL %s err: got %b expected %b", nm, e, ee); end
        checks++;
        if (lat != exp_lat(d)) begin failures++; $display("FAIL %s latency: got %0d expected %0d", nm, lat, exp_lat(d)); end
        checks++;
        if (sb != 0) begin failures++; $display("FAIL %s stallreq: %0d bad cycles expected 0", nm, sb); end
    endtask

    task automatic test_reset();
        logic [34:0] o0, o1;
        rst = 1'b0;
        drive(0, 1'b1, 1'b0, 32'd0, 4'hF, 32'd0);
        drive(1, 1'b1, 1'b0, 32'd0, 4'hF, 32'd0);
        repeat (3) @(negedge clk);
        o0 = obs(0);
        o1 = obs(1);
        checks++;
        if (o0 !== 35'd0) begin failures++; $display("FAIL reset_w0: got %h expected 0", o0); end
        checks++;
        if (o1 !== 35'd0) begin failures++; $display("FAIL reset_w2: got %h expected 0", o1); end
        drive(0, 1'b0, 1'b0, 32'd0, 4'd0, 32'd0);
        drive(1, 1'b0, 1'b0, 32'd0, 4'd0, 32'd0);
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_store_load();
        logic [34:0] o;
        acc_check("store_0x10", 1, 1'b1, 32'h10, 4'hF, 32'hDEAD_BEEF);
        @(negedge clk);
        o = obs(1);
        checks++;
        if (o[34] !== 1'b0) begin failures++; $display("FAIL ack_one_cycle: got %b expected 0", o[34]); end
        acc_check("load_0x10", 1, 1'b0, 32'h10, 4'hF, 32'd0);
        checks++;
        if (rd1 !== 32'hDEAD_BEEF) begin failures++; $display("FAIL load_0x10_const: got %h expected deadbeef", rd1); end
    endtask

    task automatic test_byte_store();
        acc_check("preload_0x20", 1, 1'b1, 32'h20, 4'hF, 32'h1122_3344);
        acc_check("byte_store_0x20", 1, 1'b1, 32'h20, 4'b0010, 32'h0000_AA00);
        acc_check("byte_load_0x20", 1, 1'b0, 32'h20, 4'h0, 32'd0);
        checks++;
        if (rd1 !== 32'h1122_AA44) begin failures++; $display("FAIL byte_merge_const: got %h expected 1122aa44", rd1); end
        acc_check("sel0_store_0x20", 1, 1'b1, 32'h20, 4'b0000, 32'hFFFF_FFFF);
        acc_check("sel0_load_0x20", 1, 1'b0, 32'h22, 4'h0, 32'd0);
    endtask

    task automatic test_out_of_range();
        logic [31:0] a;
        acc_check("preload_0x0", 1, 1'b1, 32'h0, 4'hF, 32'hCAFE_F00D);
        acc_check("oor_load_0x1000", 1, 1'b0, 32'h0000_1000, 4'hF, 32'd0);
        acc_check("oor_store_0x1000", 1, 1'b1, 32'h0000_1000, 4'hF, 32'hFFFF_FFFF);
        acc_check("load_0x0_after_oor", 1, 1'b0, 32'h0, 4'hF, 32'd0);
        for (int i = 0; i < 4; i++) begin
            a = $urandom() | 32'h0000_1000;
            acc_check("oor_random", i % 2, i[0], a, 4'hF, $urandom());
        end
        acc_check("load_0x0_after_oor_rnd", 1, 1'b0, 32'h0, 4'hF, 32'd0);
    endtask

    task automatic test_random();
        logic [31:0] a;
        // fill words 0..31 of both instances so every later load has a known value
        for (int i = 0; i < 32; i++) begin
            acc_check("fill_w2", 1, 1'b1, 32'(i * 4), 4'hF, $urandom());
            acc_check("fill_w0", 0, 1'b1, 32'(i * 4), 4'hF, $urandom());
        end
        for (int i = 0; i < 40; i++) begin
            a = 32'($urandom_range(0, 31) * 4) | 32'($urandom_range(0, 3));
            acc_check("random_op", i % 2, 1'($urandom_range(0, 1)), a,
                      4'($urandom_range(0, 15)), $urandom());
        end
    endtask

    task automatic test_back_to_back();
        int idx [8];
        logic [34:0] o;
        logic exp_ack, exp_stall, reqflag;
        logic [31:0] exp_d;
        for (int k = 0; k < 8; k++) idx[k] = $urandom_range(0, 31);
        @(negedge clk);
        drive(0, 1'b1, 1'b0, 32'(idx[0] * 4), 4'hF, 32'd0);
        reqflag = 1'b1;
        for (int n = 1; n <= 16; n++) begin
            @(negedge clk);
            o = obs(0);
            exp_ack   = (n % 2 == 1);
            exp_stall = reqflag & ~exp_ack;
            checks++;
            if (o[34] !== exp_ack) begin failures++; $display("FAIL b2b_ack cyc%0d: got %b expected %b", n, o[34], exp_ack); end
            checks++;
            if (o[32] !== exp_stall) begin failures++; $display("FAIL b2b_stall cyc%0d: got %b expected %b", n, o[32], exp_stall); end
            if (exp_ack) begin
                exp_d = ref_mem[0][idx[(n - 1) / 2]];
                checks++;
                if (o[31:0] !== exp_d) begin failures++; $display("FAIL b2b_data cyc%0d: got %h expected %h", n, o[31:0], exp_d); end
                if (n == 15) begin
                    drive(0, 1'b0, 1'b0, 32'd0, 4'd0, 32'd0);
                    reqflag = 1'b0;
                end else begin
                    drive(0, 1'b1, 1'b0, 32'(idx[(n + 1) / 2] * 4), 4'hF, 32'd0);
                end
            end
        end
    endtask

    task automatic test_drop_req();
        logic [34:0] o;
        int lat;
        @(negedge clk);
        drive(1, 1'b1, 1'b1, 32'h30, 4'hF, 32'h5A5A_5A5A);
        @(posedge clk);
        lat = 0;
        @(negedge clk);
        // req dropped and inputs scrambled after accept: must be ignored
        drive(1, 1'b0, 1'b1, 32'h34, 4'hF, 32'hFFFF_FFFF);
        lat = 1;
        o = obs(1);
        while (o[34] !== 1'b1 && lat < 40) begin
            @(negedge clk);
            lat++;
            o = obs(1);
        end
        model_store(1, 32'h30, 4'hF, 32'h5A5A_5A5A);
        checks++;
        if (lat != 3) begin failures++; $display("FAIL drop_req_ack latency: got %0d expected 3", lat); end
        drive(1, 1'b0, 1'b0, 32'd0, 4'd0, 32'd0);
        acc_check("drop_req_load_0x30", 1, 1'b0, 32'h30, 4'hF, 32'd0);
        acc_check("drop_req_load_0x34", 1, 1'b0, 32'h34, 4'hF, 32'd0);
        checks++;
        if (ref_mem[1][12] !== 32'h5A5A_5A5A || rd1 !== ref_mem[1][13]) begin
            failures++; $display("FAIL drop_req_model: got %h expected 5a5a5a5a", ref_mem[1][12]);
        end
    endtask

    task automatic test_reset_in_wait();
        logic [34:0] o;
        acc_check("rst_preload_0x40", 1, 1'b1, 32'h40, 4'hF, 32'h1357_9BDF);
        acc_check("rst_preread_0x40", 1, 1'b0, 32'h40, 4'hF, 32'd0);
        @(negedge clk);
        drive(1, 1'b1, 1'b1, 32'h40, 4'hF, 32'hFFFF_0000);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        o = obs(1);
        checks++;
        if (o !== 35'd0) begin failures++; $display("FAIL reset_in_wait outputs: got %h expected 0", o); end
        @(negedge clk);
        drive(1, 1'b0, 1'b0, 32'd0, 4'd0, 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        acc_check("rst_load_0x40", 1, 1'b0, 32'h40, 4'hF, 32'd0);
        checks++;
        if (rd1 !== 32'h1357_9BDF) begin failures++; $display("FAIL reset_in_wait_const: got %h expected 13579bdf", rd1); end
    endtask

    initial begin
        drive(0, 1'b0, 1'b0, 32'd0, 4'd0, 32'd0);
        drive(1, 1'b0, 1'b0, 32'd0, 4'd0, 32'd0);
        test_reset();
        test_store_load();
        test_byte_store();
        test_out_of_range();
        test_random();
        test_back_to_back();
        test_drop_req();
        test_reset_in_wait();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
